weight_sram_bank: RTL and testbench

WEIGHT_SRAM_BANK -- requirements
Module: weight_sram_bank

---
 rtl/weight_sram_bank.sv | 113 +++++++++++
 tb/tb_weight_sram_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_sram_bank.sv
// rtl/weight_sram_bank.sv - double-buffered multi-bank weight SRAM
//
// Purpose:
//   NUM_BANKS banks, each holding two pages of DEPTH weight words. Reads are
//   served from the active page while a new weight set is streamed into the
//   shadow page; swap exchanges the roles of the two pages in every bank at once.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   wr_valid     write beat offered
//   wr_ready     write beat can be accepted (combinational)
//   wr_bank      target bank of the write beat
//   wr_first     beat starts a new load; it lands at address 0
//   wr_data      weight word to write
//   rd_en        read request
//   rd_bank      bank to read
//   rd_addr      word address within the active page
//   rd_valid     rd_data holds the result of the previous cycle's request
//   rd_data      read word, held while rd_valid is low
//   swap         exchange active/shadow pages of all banks
//   active_page  page currently served to readers
//   bank_full    per bank: shadow page completely written

module weight_sram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BANK_W-1:0]       wr_bank,
  input  logic                    wr_first,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [BANK_W-1:0]       rd_bank,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    swap,
  output logic                    active_page,
  output logic [2**BANK_W-1:0]    bank_full
);

  localparam int NUM_BANKS = 2**BANK_W;
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int MEM_WORDS = NUM_BANKS * 2 * DEPTH;
  localparam int IDX_W     = BANK_W + 1 + ADDR_WIDTH;

  // Flat storage indexed by {bank, page, word}.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] wptr [NUM_BANKS];

  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [IDX_W-1:0]      wr_index;
  logic [IDX_W-1:0]      rd_index;

  // A first beat is always accepted so a new load can restart a full bank.
  assign wr_ready = !bank_full[wr_bank] || wr_first;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_addr  = wr_first ? '0 : wptr[wr_bank];

  // Writes target the shadow page, reads the active page, so the two ports
  // never touch the same word and no bypass is needed.
  assign wr_index = {wr_bank, ~active_page, wr_addr};
  assign rd_index = {rd_bank, active_page, rd_addr};

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_page <= 1'b0;
      bank_full   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        wptr[b] <= '0;
      end
    end else begin
      // The read samples the pre-swap active_page, so a read issued together
      // with swap still returns the old page.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_index];
      end

      // swap wins over a coincident write's pointer update; the write data
      // itself still lands in the old shadow page above.
      if (swap) begin
        active_page <= ~active_page;
        bank_full   <= '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
          wptr[b] <= '0;
        end
      end else if (wr_fire) begin
        wptr[wr_bank]      <= wr_addr + ADDR_WIDTH'(1);
        // Writing the last word marks the page full; a first beat writes
        // address 0 and therefore clears the flag.
        bank_full[wr_bank] <= &wr_addr;
      end
    end
  end

endmodule

// File: tb/tb_weight_sram_bank.sv
// tb/tb_weight_sram_bank.sv - directed self-checking bench for weight_sram_bank

module tb_weight_sram_bank;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic          wr_first;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          swap;
  logic          active_page;
  logic [NB-1:0] bank_full;

  int total = 0;
  int bad   = 0;

  weight_sram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .wr_first(wr_first), .wr_data(wr_data),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .swap(swap), .active_page(active_page), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    wr_first = 1'b0;
    rd_en    = 1'b0;
    swap     = 1'b0;
  endtask

  task automatic put(input logic [BW-1:0] b, input logic first, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_bank  = b;
    wr_first = first;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    wr_first = 1'b0;
  endtask

  task automatic load(input logic [BW-1:0] b, input logic [DW-1:0] base);
    put(b, 1'b1, base);
    for (int i = 1; i < DEPTH; i++) put(b, 1'b0, base + DW'(i));
  endtask

  task automatic do_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  task automatic rd(input logic [BW-1:0] b, input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_bank = b;
    rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    wr_bank = '0; wr_data = '0; rd_bank = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (active_page !== 1'b0) begin bad++; $display("FAIL reset_active_page got=%b exp=0", active_page); end
    total++; if (bank_full !== 4'b0000) begin bad++; $display("FAIL reset_bank_full got=%b exp=0000", bank_full); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=00000000", rd_data); end
    rst = 1'b0;
    step();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_load_swap_read();
    load(2'd2, 32'd0);
    total++; if (bank_full !== 4'b0100) begin bad++; $display("FAIL load_full got=%b exp=0100", bank_full); end
    do_swap();
    total++; if (active_page !== 1'b1) begin bad++; $display("FAIL load_swap_page got=%b exp=1", active_page); end
    total++; if (bank_full !== 4'b0000) begin bad++; $display("FAIL load_swap_full got=%b exp=0000", bank_full); end
    rd(2'd2, 4'd0);
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin bad++; $display("FAIL load_rd0 got=%b/%h exp=1/00000000", rd_valid, rd_data); end
    rd(2'd2, 4'd5);
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd5) begin bad++; $display("FAIL load_rd5 got=%b/%h exp=1/00000005", rd_valid, rd_data); end
    rd(2'd2, 4'd15);
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd15) begin bad++; $display("FAIL load_rd15 got=%b/%h exp=1/0000000f", rd_valid, rd_data); end
    step();
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'd15) begin bad++; $display("FAIL load_hold got=%b/%h exp=0/0000000f", rd_valid, rd_data); end
  endtask

  task automatic test_full();
    load(2'd0, 32'd100);
    total++; if (bank_full !== 4'b0001) begin bad++; $display("FAIL full_flag got=%b exp=0001", bank_full); end
    wr_valid = 1'b1; wr_bank = 2'd0; wr_first = 1'b0; wr_data = 32'hDEAD_BEEF;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_stall got=%b exp=0", wr_ready); end
    wr_bank = 2'd1;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_other_bank got=%b exp=1", wr_ready); end
    wr_bank = 2'd0; wr_first = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_first_ready got=%b exp=1", wr_ready); end
    wr_first = 1'b0;
    step();
    wr_valid = 1'b0;
    total++; if (bank_full !== 4'b0001) begin bad++; $display("FAIL full_after_stall got=%b exp=0001", bank_full); end
    do_swap();
    rd(2'd0, 4'd0);
    total++; if (rd_data !== 32'd100) begin bad++; $display("FAIL full_rd0 got=%h exp=%h", rd_data, 32'd100); end
    rd(2'd0, 4'd15);
    total++; if (rd_data !== 32'd115) begin bad++; $display("FAIL full_rd15 got=%h exp=%h", rd_data, 32'd115); end
  endtask

  task automatic test_swap_read();
    do_swap();
    put(2'd1, 1'b1, 32'd0); put(2'd1, 1'b0, 32'd1); put(2'd1, 1'b0, 32'd2); put(2'd1, 1'b0, 32'hAAAA_AAAA);
    do_swap();
    put(2'd1, 1'b1, 32'd0); put(2'd1, 1'b0, 32'd1); put(2'd1, 1'b0, 32'd2); put(2'd1, 1'b0, 32'h5555_5555);
    rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 4'd3; swap = 1'b1;
    step();
    rd_en = 1'b0; swap = 1'b0;
    total++; if (rd_data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL swaprd_old got=%h exp=aaaaaaaa", rd_data); end
    total++; if (active_page !== 1'b1) begin bad++; $display("FAIL swaprd_page got=%b exp=1", active_page); end
    rd(2'd1, 4'd3);
    total++; if (rd_data !== 32'h5555_5555) begin bad++; $display("FAIL swaprd_new got=%h exp=55555555", rd_data); end
  endtask

  task automatic test_write_swap();
    put(2'd3, 1'b1, 32'h11);
    wr_valid = 1'b1; wr_bank = 2'd3; wr_first = 1'b0; wr_data = 32'h1234_5678; swap = 1'b1;
    step();
    idle();
    total++; if (active_page !== 1'b0) begin bad++; $display("FAIL wrswap_page got=%b exp=0", active_page); end
    total++; if (bank_full !== 4'b0000) begin bad++; $display("FAIL wrswap_full got=%b exp=0000", bank_full); end
    rd(2'd3, 4'd1);
    total++; if (rd_data !== 32'h1234_5678) begin bad++; $display("FAIL wrswap_word got=%h exp=12345678", rd_data); end
    rd(2'd3, 4'd0);
    total++; if (rd_data !== 32'h11) begin bad++; $display("FAIL wrswap_word0 got=%h exp=00000011", rd_data); end
    put(2'd3, 1'b0, 32'h77);
    do_swap();
    rd(2'd3, 4'd0);
    total++; if (rd_data !== 32'h77) begin bad++; $display("FAIL wrswap_ptr_clear got=%h exp=00000077", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] rb [8];
    logic [AW-1:0] ra [8];
    logic [DW-1:0] ex [8];
    rb = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2};
    ra = '{4'd0, 4'd3, 4'd7, 4'd0, 4'd1, 4'd15, 4'd2, 4'd9};
    ex = '{32'd0, 32'h5555_5555, 32'd7, 32'h77, 32'd1, 32'd15, 32'd2, 32'd9};
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_bank = rb[i]; rd_addr = ra[i];
      wr_valid = 1'b1; wr_bank = 2'd0; wr_first = (i == 0); wr_data = 32'h200 + DW'(i);
      step();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== ex[i]) begin
        bad++; $display("FAIL b2b_rd%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, ex[i]);
      end
    end
    idle();
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b exp=0", rd_valid); end
    do_swap();
    rd(2'd0, 4'd0);
    total++; if (rd_data !== 32'h200) begin bad++; $display("FAIL b2b_wr0 got=%h exp=00000200", rd_data); end
    rd(2'd0, 4'd7);
    total++; if (rd_data !== 32'h207) begin bad++; $display("FAIL b2b_wr7 got=%h exp=00000207", rd_data); end
    rd(2'd0, 4'd8);
    total++; if (rd_data !== 32'd108) begin bad++; $display("FAIL b2b_untouched got=%h exp=%h", rd_data, 32'd108); end
  endtask

  task automatic test_reset_midload();
    do_swap();
    load(2'd2, 32'h300);
    put(2'd1, 1'b1, 32'h900);
    put(2'd1, 1'b0, 32'h901);
    total++; if (bank_full !== 4'b0100 || active_page !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b/%b exp=0100/1", bank_full, active_page); end
    rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 4'd0;
    step();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", rd_valid); end
    wr_valid = 1'b1; wr_bank = 2'd1; wr_first = 1'b0; wr_data = 32'h902;
    #2 rst = 1'b1;
    #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", rd_valid); end
    total++; if (active_page !== 1'b0) begin bad++; $display("FAIL rst_async_page got=%b exp=0", active_page); end
    total++; if (bank_full !== 4'b0000) begin bad++; $display("FAIL rst_async_full got=%b exp=0000", bank_full); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_async_data got=%h exp=00000000", rd_data); end
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_no_pulse got=%b exp=0", rd_valid); end
    wr_valid = 1'b1; wr_bank = 2'd1; wr_first = 1'b0; wr_data = 32'hABC;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
    step();
    wr_valid = 1'b0;
    do_swap();
    rd(2'd1, 4'd0);
    total++; if (rd_data !== 32'hABC) begin bad++; $display("FAIL rst_restart_addr0 got=%h exp=00000abc", rd_data); end
  endtask

  initial begin
    test_reset();
    test_load_swap_read();
    test_full();
    test_swap_read();
    test_write_swap();
    test_back_to_back();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
